// File: rtl/int_ctrl.sv
// int_ctrl: pending/mask/edge interrupt controller on the data bus.
// Optional INT_CTRL_SYNC_EN adds a 2-flop input synchronizer.
module int_ctrl #(
    parameter int          N_SRC     = 8,
    parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ce,
    input  logic [N_SRC-1:0] i_src,
    input  logic             i_bus_we,
    input  logic [15:0]      i_bus_waddr,
    input  logic [15:0]      i_bus_wdata,
    input  logic [15:0]      i_bus_raddr,
    output logic [15:0]      o_bus_rdata,
    output logic             o_bus_hit,
    output logic             o_int
);

    localparam int PADW = 16 - N_SRC;

    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] edge_q, edge_d;
    logic [N_SRC-1:0] sq_q;
    logic             int_q;
    logic [N_SRC-1:0] s;
    logic [N_SRC-1:0] hw_set;
    logic [N_SRC-1:0] w1c;
    logic [N_SRC-1:0] frc;
    logic [N_SRC-1:0] act;
    logic [15:0]      roff;
    logic [15:0]      woff;
    logic             wr_en;
    logic [3:0]       cause_idx;
    logic [15:0]      cause;
    logic             unused_wdata;

    assign roff      = i_bus_raddr - BASE_ADDR;
    assign woff      = i_bus_waddr - BASE_ADDR;
    assign o_bus_hit = (roff < 16'd5);
    assign wr_en     = i_bus_we && i_ce && (woff < 16'd5);

    assign unused_wdata = ^i_bus_wdata[15:N_SRC];

`ifdef INT_CTRL_SYNC_EN
    logic [N_SRC-1:0] sync1_q;
    logic [N_SRC-1:0] sync2_q;

    // Two-flop synchronizer, free-running on i_clk
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= i_src;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q;
`else
    assign s = i_src;
`endif

    // Hardware set terms and register write decode
    always_comb begin
        hw_set = (edge_q & s & ~sq_q) | (~edge_q & s);
        w1c    = '0;
        frc    = '0;
        mask_d = mask_q;
        edge_d = edge_q;
        if (wr_en) begin
            case (woff)
                16'd0:   w1c    = i_bus_wdata[N_SRC-1:0];
                16'd1:   mask_d = i_bus_wdata[N_SRC-1:0];
                16'd2:   edge_d = i_bus_wdata[N_SRC-1:0];
                16'd4:   frc    = i_bus_wdata[N_SRC-1:0];
                default: ;
            endcase
        end
        // Set (hardware or forced) beats a same-cycle clear
        pend_d = (pend_q & ~w1c) | frc | hw_set;
    end

    // Controller state, advanced only on clock-enable cycles
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pend_q <= '0;
            mask_q <= '0;
            edge_q <= '0;
            sq_q   <= '0;
            int_q  <= 1'b0;
        end else if (i_ce) begin
            pend_q <= pend_d;
            mask_q <= mask_d;
            edge_q <= edge_d;
            sq_q   <= s;
            int_q  <= |(pend_q & mask_q);
        end
    end

    assign o_int = int_q;

    // Lowest-index enabled pending source
    always_comb begin
        act       = pend_q & mask_q;
        cause_idx = 4'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (act[i]) cause_idx = 4'(i);
        end
        cause = (|act) ? {1'b1, 11'b0, cause_idx} : 16'h0000;
    end

    // Combinational register read mux
    always_comb begin
        o_bus_rdata = 16'h0000;
        case (roff)
            16'd0:   o_bus_rdata = {{PADW{1'b0}}, pend_q};
            16'd1:   o_bus_rdata = {{PADW{1'b0}}, mask_q};
            16'd2:   o_bus_rdata = {{PADW{1'b0}}, edge_q};
            16'd3:   o_bus_rdata = cause;
            default: o_bus_rdata = 16'h0000;
        endcase
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl (default N_SRC=8, BASE_ADDR=16'hFF00).
module tb_int_ctrl;

`ifdef INT_CTRL_SYNC_EN
    localparam int PLAT = 3;
`else
    localparam int PLAT = 1;
`endif

    localparam logic [15:0] A_PEND  = 16'hFF00;
    localparam logic [15:0] A_MASK  = 16'hFF01;
    localparam logic [15:0] A_EDGE  = 16'hFF02;
    localparam logic [15:0] A_CAUSE = 16'hFF03;
    localparam logic [15:0] A_FORCE = 16'hFF04;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b1;
    logic [7:0]  src = 8'h00;
    logic        we = 1'b0;
    logic [15:0] waddr = 16'h0000;
    logic [15:0] wdata = 16'h0000;
    logic [15:0] raddr = 16'h0000;
    logic [15:0] rdata;
    logic        hit;
    logic        oint;

    int checks = 0;
    int errors = 0;

    always #50 clk = ~clk;

    int_ctrl #(.N_SRC(8), .BASE_ADDR(16'hFF00)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_ce        (ce),
        .i_src       (src),
        .i_bus_we    (we),
        .i_bus_waddr (waddr),
        .i_bus_wdata (wdata),
        .i_bus_raddr (raddr),
        .o_bus_rdata (rdata),
        .o_bus_hit   (hit),
        .o_int       (oint)
    );

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        step();
        we    = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [15:0] a,
                      input logic [15:0] exp);
        raddr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic chk_int(input string tag, input logic exp);
        chk(tag, {15'b0, oint}, {15'b0, exp});
    endtask

    initial begin
        int n;
        bit risen;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        // Reset state and address window
        rd("rst_pend", A_PEND, 16'h0000);
        rd("rst_mask", A_MASK, 16'h0000);
        rd("rst_edge", A_EDGE, 16'h0000);
        rd("rst_cause", A_CAUSE, 16'h0000);
        rd("rst_force", A_FORCE, 16'h0000);
        chk_int("rst_oint", 1'b0);
        for (int a = 0; a < 5; a++) begin
            raddr = 16'hFF00 + 16'(a);
            #1;
            chk("hit_in", {15'b0, hit}, 16'h0001);
        end
        raddr = 16'hFF05;
        #1;
        chk("hit_ff05", {15'b0, hit}, 16'h0000);
        raddr = 16'hFEFF;
        #1;
        chk("hit_feff", {15'b0, hit}, 16'h0000);
        wr(16'hFF05, 16'hFFFF);
        wr(16'hFEFF, 16'hFFFF);
        rd("oob_mask", A_MASK, 16'h0000);
        rd("oob_edge", A_EDGE, 16'h0000);

        // Edge source 2, one-cycle pulse
        wr(A_MASK, 16'h0004);
        wr(A_EDGE, 16'h0004);
        src = 8'h04;
        step();
        src = 8'h00;
        repeat (PLAT - 1) step();
        rd("e2_pend", A_PEND, 16'h0004);
        rd("e2_cause", A_CAUSE, 16'h8002);
        chk_int("e2_oint_lo", 1'b0);
        step();
        chk_int("e2_oint_hi", 1'b1);
        wr(A_PEND, 16'h0004);
        rd("e2_w1c_pend", A_PEND, 16'h0000);
        chk_int("e2_oint_hold", 1'b1);
        step();
        chk_int("e2_oint_clr", 1'b0);

        // Level source 5, set beats W1C
        wr(A_MASK, 16'h0020);
        src = 8'h20;
        repeat (PLAT) step();
        rd("l5_pend", A_PEND, 16'h0020);
        step();
        chk_int("l5_oint", 1'b1);
        wr(A_PEND, 16'h0020);
        rd("l5_setwins", A_PEND, 16'h0020);
        step();
        chk_int("l5_oint_stay", 1'b1);
        src = 8'h00;
        repeat (PLAT) step();
        wr(A_PEND, 16'h0020);
        rd("l5_clr", A_PEND, 16'h0000);
        step();
        chk_int("l5_oint_clr", 1'b0);

        // Priority among sources 1 and 6, then FORCE
        src = 8'h42;
        step();
        src = 8'h00;
        repeat (PLAT) step();
        wr(A_MASK, 16'h0042);
        rd("pr_pend", A_PEND, 16'h0042);
        rd("pr_cause1", A_CAUSE, 16'h8001);
        wr(A_MASK, 16'h0040);
        rd("pr_cause6", A_CAUSE, 16'h8006);
        wr(A_MASK, 16'h0041);
        wr(A_FORCE, 16'h0001);
        rd("fr_pend", A_PEND, 16'h0043);
        rd("fr_cause0", A_CAUSE, 16'h8000);
        rd("fr_read0", A_FORCE, 16'h0000);
        wr(A_MASK, 16'h0000);
        rd("cause_none", A_CAUSE, 16'h0000);
        wr(A_MASK, 16'hFFFF);
        rd("mask_width", A_MASK, 16'h00FF);
        wr(A_EDGE, 16'hFFFF);
        rd("edge_width", A_EDGE, 16'h00FF);
        wr(A_PEND, 16'hFFFF);
        rd("pend_clrall", A_PEND, 16'h0000);
        wr(A_MASK, 16'h0000);

        // Clock-enable gap with edge source 0 rising
        wr(A_EDGE, 16'h0001);
        wr(A_MASK, 16'h0001);
        ce  = 1'b0;
        src = 8'h01;
        wr(A_MASK, 16'h00FF);
        repeat (9) step();
        rd("ce_pend", A_PEND, 16'h0000);
        rd("ce_mask", A_MASK, 16'h0001);
        chk_int("ce_oint", 1'b0);
        ce = 1'b1;
        step();
        rd("ce_pend_set", A_PEND, 16'h0001);
        chk_int("ce_oint_lo", 1'b0);
        step();
        chk_int("ce_oint_hi", 1'b1);

        // Asynchronous reset mid-operation
        #10;
        rst = 1'b1;
        src = 8'h00;
        #1;
        chk_int("ar_oint", 1'b0);
        rd("ar_pend", A_PEND, 16'h0000);
        rd("ar_mask", A_MASK, 16'h0000);
        rd("ar_edge", A_EDGE, 16'h0000);
        rd("ar_cause", A_CAUSE, 16'h0000);
        step();
        rst = 1'b0;
        step();

        // Edge-to-interrupt latency on source 0
        wr(A_MASK, 16'h0001);
        wr(A_EDGE, 16'h0001);
        step();
        src   = 8'h01;
        n     = 0;
        risen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!risen) begin
                step();
                n++;
                if (oint) risen = 1'b1;
            end
        end
        chk("lat_oint", 16'(n), 16'(PLAT + 1));
        rd("lat_cause", A_CAUSE, 16'h8000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Memory-mapped interrupt controller between peripheral interrupt lines and the CPU's single `i_int` input. It latches up to `N_SRC` interrupt sources as pending bits, applies a per-source mask, and raises one registered request to the CPU. It also exposes a cause register so the handler at vector 0x0002 can find the highest-priority source. It sits on the CPU's data-memory bus alongside RAM and claims a small address window.

## Interface
- `N_SRC`, 8, number of interrupt sources, legal 1..15
- `BASE_ADDR`, 16'hFF00, word address of register 0; window is BASE_ADDR..BASE_ADDR+4
- `i_clk` in 1, clock
- `i_rst` in 1, reset; asynchronous, active-high
- `i_ce` in 1, clock enable shared with the CPU; no state changes when low
- `i_src` in N_SRC, raw interrupt request lines
- `i_bus_we` in 1, CPU `o_ram_we`
- `i_bus_waddr` in 16, CPU `o_mem_write_addr`
- `i_bus_wdata` in 16, CPU `o_mem_write_data`
- `i_bus_raddr` in 16, CPU `o_mem_read_addr`
- `o_bus_rdata` out 16, combinational register read data; 0 when not hit
- `o_bus_hit` out 1, combinational; high when `i_bus_raddr` is in the window (system read-mux select)
- `o_int` out 1, registered interrupt request to CPU `i_int`

## Operation
- Registers, offsets from BASE_ADDR. Bits at and above N_SRC read 0 and ignore writes.
  - +0 PENDING: read; write-1-to-clear.
  - +1 MASK: read/write; 1 = enabled.
  - +2 EDGE: read/write; 1 = rising-edge source, 0 = level source.
  - +3 CAUSE: read-only. Bit15 = valid. [3:0] = lowest index i with PENDING[i] & MASK[i]. The whole register reads 0 when no such i exists.
  - +4 FORCE: write-only; write-1-to-set PENDING; reads 0.
- Register writes happen only when `i_bus_we && i_ce`. Writes to offsets outside 0..4 inside a larger decode are ignored.
- Source sampling, per bit, on every `i_ce` cycle, from the sampled source `s` (raw, or synchronized when the macro is set):
  - Edge mode: set PENDING when `s` = 1 and the previous sample `s_q` = 0. `s_q` updates every `i_ce` cycle regardless of mode.
  - Level mode: set PENDING on every cycle `s` = 1.
- Simultaneous set and W1C on the same bit in the same cycle: set wins.
- FORCE and hardware set on the same bit: bit is set.
- `o_int` <= |(PENDING & MASK), registered on `i_ce`.
  - Stays high until software clears or masks every enabled pending bit.
  - The CPU's own `int_enable` prevents re-entry.
  - Handler sequence: read CAUSE, service, write 1<<idx to +0, then JMP R0.
- Priority is fixed: lowest index wins.
- Reset values: PENDING 0, MASK 0, EDGE 0, `s_q` 0, synchronizer flops 0, `o_int` 0.
- Reset is asynchronous and may arrive mid-operation. All state clears immediately and `o_int` drops the same cycle reset asserts.

## Timing
- Edge on `i_src` sampled at ce-cycle n:
  - PENDING set at end of n.
  - `o_int` high at end of n+1.
  - With SYNC, add 2 ce cycles.
- MASK or W1C write in ce-cycle n: `o_int` reflects it at end of n+1.
- Reads have zero latency; `o_bus_rdata` and CAUSE follow the current register state combinationally.
- When `i_ce` is low for k cycles, all state holds. A source pulse that rises and falls entirely within a ce-low gap is not detected. This is documented behaviour, not a fault.

## Configuration
- `INT_CTRL_SYNC_EN`:
  - Defined: each `i_src` bit passes through a two-flop synchronizer clocked on `i_clk` (ungated by `i_ce`) before sampling. This adds 2 cycles of latency; asynchronous sources are legal.
  - Undefined: `i_src` is sampled directly and must be synchronous to `i_clk`.

## Test plan
- Reset, then read +0..+4 → all 0. `o_int` = 0. `o_bus_hit` = 1 for 16'hFF00..16'hFF04 and 0 for 16'hFF05.
- MASK = 16'h0004, EDGE = 16'h0004, pulse `i_src[2]` for one cycle → PENDING = 16'h0004, `o_int` rises 2 cycles after the sample, CAUSE = 16'h8002. Write 16'h0004 to +0 → `o_int` = 0 one cycle later.
- Level source 5 held high, MASK = 16'h0020, W1C 16'h0020 → PENDING bit 5 re-sets (set wins) and `o_int` stays 1. Drop `i_src[5]`, then W1C → `o_int` = 0.
- Sources 1 and 6 pending, MASK = 16'h0042 → CAUSE = 16'h8001. MASK = 16'h0040 → CAUSE = 16'h8006. Write FORCE 16'h0001 with MASK = 16'h0041 → CAUSE = 16'h8000.
- `i_ce` held low for 10 cycles while an edge source rises and stays high → no change until `i_ce` returns, then PENDING sets on the first ce cycle. Assert `i_rst` mid-test → `o_int` = 0 immediately and all registers read 0.
- With `INT_CTRL_SYNC_EN`, edge on `i_src[0]` with MASK = 1 → `o_int` rises 4 cycles after the edge, versus 2 without the macro.
